// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/forward controller with shadow E/M/W Tnew tracking and mult/div busy counter
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_used,
  input  logic              d_rt_used,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [1:0]        d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        mfrse_c,
  output logic [1:0]        mfrte_c,
  output logic              md_busy
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [REG_AW-1:0] e_rs, e_rt, e_dst, m_dst, w_dst;
  logic [1:0]        e_tnew, m_tnew, w_tnew;
  logic              e_md_start, e_md_div;
  logic [CW-1:0]     md_cnt;
  logic              rs_haz, rt_haz;
  function automatic logic [1:0] dec(input logic [1:0] t);
    return t == 2'd0 ? 2'd0 : t - 2'd1;
  endfunction
  // shadow pipeline: D fields enter E unless stalled (bubble), older stages age their Tnew
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs       <= '0;
      e_rt       <= '0;
      e_dst      <= '0;
      e_tnew     <= '0;
      e_md_start <= 1'b0;
      e_md_div   <= 1'b0;
      m_dst      <= '0;
      m_tnew     <= '0;
      w_dst      <= '0;
      w_tnew     <= '0;
    end else begin
      e_rs       <= stall ? '0 : d_rs;
      e_rt       <= stall ? '0 : d_rt;
      e_dst      <= stall ? '0 : d_dst;
      e_tnew     <= stall ? '0 : d_tnew;
      e_md_start <= !stall && d_md_start;
      e_md_div   <= !stall && d_md_div;
      m_dst      <= e_dst;
      m_tnew     <= dec(e_tnew);
      w_dst      <= m_dst;
      w_tnew     <= dec(m_tnew);
    end
  end
  // mult/div busy counter, loaded as the start leaves E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) md_cnt <= '0;
    else md_cnt <= e_md_start ? (e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                              : (md_cnt != '0 ? md_cnt - CW'(1) : md_cnt);
  end
  // stall when a source is needed before an in-flight producer can supply it; forward newest ready value into E
  always_comb begin
    rs_haz  = d_rs_used && d_rs != '0 &&
              ((e_dst == d_rs && e_tnew > d_tuse_rs) || (m_dst == d_rs && m_tnew > d_tuse_rs));
    rt_haz  = d_rt_used && d_rt != '0 &&
              ((e_dst == d_rt && e_tnew > d_tuse_rt) || (m_dst == d_rt && m_tnew > d_tuse_rt));
    md_busy = e_md_start || md_cnt != '0;
    stall   = rs_haz || rt_haz || (d_md_use && md_busy);
    mfrse_c = (e_rs != '0 && m_dst == e_rs && m_tnew == 2'd0) ? 2'b01 :
              (e_rs != '0 && w_dst == e_rs && w_tnew == 2'd0) ? 2'b10 : 2'b00;
    mfrte_c = (e_rt != '0 && m_dst == e_rt && m_tnew == 2'd0) ? 2'b01 :
              (e_rt != '0 && w_dst == e_rt && w_tnew == 2'd0) ? 2'b10 : 2'b00;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl stall, forwarding and mult/div busy behaviour
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       d_rs_used, d_rt_used, d_md_start, d_md_div, d_md_use;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] mfrse_c, mfrte_c;
  logic [5:0] obs;
  int tests, fails;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       rs_used, rt_used;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       md_start, md_div, md_use;
  } instr_t;

  instr_t     prog_q[$];
  logic [5:0] exp_q[$];

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .mfrse_c(mfrse_c), .mfrte_c(mfrte_c), .md_busy(md_busy)
  );

  always #5 clk = ~clk;
  assign obs = {stall, mfrse_c, mfrte_c, md_busy};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction
  function automatic instr_t alu(input logic [4:0] d, s, t);
    instr_t i;
    i = '0;
    i.rs = s; i.rt = t; i.rs_used = 1'b1; i.rt_used = 1'b1;
    i.tuse_rs = 2'd1; i.tuse_rt = 2'd1; i.dst = d; i.tnew = 2'd1;
    return i;
  endfunction
  function automatic instr_t ld(input logic [4:0] d, s);
    instr_t i;
    i = '0;
    i.rs = s; i.rs_used = 1'b1; i.tuse_rs = 2'd1; i.dst = d; i.tnew = 2'd2;
    return i;
  endfunction
  function automatic instr_t beq(input logic [4:0] s, t);
    instr_t i;
    i = '0;
    i.rs = s; i.rt = t; i.rs_used = 1'b1; i.rt_used = 1'b1;
    return i;
  endfunction
  function automatic instr_t md(input logic dv);
    instr_t i;
    i = '0;
    i.md_start = 1'b1; i.md_div = dv; i.md_use = 1'b1;
    return i;
  endfunction
  function automatic instr_t mflo(input logic [4:0] d);
    instr_t i;
    i = '0;
    i.md_use = 1'b1; i.dst = d; i.tnew = 2'd1;
    return i;
  endfunction
  function automatic logic [5:0] ex(input logic s, input logic [1:0] a, b, input logic bz);
    return {s, a, b, bz};
  endfunction

  task automatic apply(input instr_t i);
    d_rs = i.rs; d_rt = i.rt; d_rs_used = i.rs_used; d_rt_used = i.rt_used;
    d_tuse_rs = i.tuse_rs; d_tuse_rt = i.tuse_rt; d_dst = i.dst; d_tnew = i.tnew;
    d_md_start = i.md_start; d_md_div = i.md_div; d_md_use = i.md_use;
  endtask

  task automatic sched(input instr_t i, input logic [5:0] e);
    prog_q.push_back(i);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    apply(nop());
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(6'b0);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_hold: got %b expected %b", obs, e); end
    reset = 1'b1;
    @(posedge clk); #1;
    apply(ld(5'd2, 5'd0));
    @(posedge clk); #1;
    apply(alu(5'd9, 5'd2, 5'd0));
    exp_q.push_back(ex(1'b1, 2'b00, 2'b00, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_pre_stall: got %b expected %b", obs, e); end
    #1 reset = 1'b0;
    exp_q.push_back(6'b0);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_async_clear: got %b expected %b", obs, e); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(nop());
    @(posedge clk); #1;
    exp_q.push_back(6'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_first_cycle: got %b expected %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_fwd();
    logic [5:0] e;
    drain();
    sched(alu(5'd1, 5'd0, 5'd0), 6'b0);
    sched(alu(5'd5, 5'd1, 5'd0), 6'b0);
    sched(nop(), ex(1'b0, 2'b01, 2'b00, 1'b0));
    sched(alu(5'd7, 5'd0, 5'd0), 6'b0);
    sched(nop(), 6'b0);
    sched(alu(5'd8, 5'd0, 5'd7), 6'b0);
    sched(nop(), ex(1'b0, 2'b00, 2'b10, 1'b0));
    for (int c = 0; prog_q.size() > 0; c++) begin
      apply(prog_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL alu_fwd cycle %0d: got %b expected %b", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [5:0] e;
    drain();
    sched(ld(5'd2, 5'd0), 6'b0);
    sched(alu(5'd9, 5'd2, 5'd0), ex(1'b1, 2'b00, 2'b00, 1'b0));
    sched(alu(5'd9, 5'd2, 5'd0), 6'b0);
    sched(nop(), ex(1'b0, 2'b10, 2'b00, 1'b0));
    for (int c = 0; prog_q.size() > 0; c++) begin
      apply(prog_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL load_use cycle %0d: got %b expected %b", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_use();
    logic [5:0] e;
    drain();
    sched(alu(5'd3, 5'd0, 5'd0), 6'b0);
    sched(beq(5'd3, 5'd0), ex(1'b1, 2'b00, 2'b00, 1'b0));
    sched(beq(5'd3, 5'd0), 6'b0);
    sched(nop(), ex(1'b0, 2'b10, 2'b00, 1'b0));
    sched(ld(5'd3, 5'd0), 6'b0);
    sched(beq(5'd0, 5'd3), ex(1'b1, 2'b00, 2'b00, 1'b0));
    sched(beq(5'd0, 5'd3), ex(1'b1, 2'b00, 2'b00, 1'b0));
    sched(beq(5'd0, 5'd3), 6'b0);
    sched(nop(), 6'b0);
    for (int c = 0; prog_q.size() > 0; c++) begin
      apply(prog_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL branch_use cycle %0d: got %b expected %b", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md();
    logic [5:0] e;
    drain();
    sched(md(1'b1), 6'b0);
    for (int i = 0; i < 11; i++) sched(mflo(5'd10), ex(1'b1, 2'b00, 2'b00, 1'b1));
    sched(mflo(5'd10), 6'b0);
    sched(nop(), 6'b0);
    sched(md(1'b0), 6'b0);
    for (int i = 0; i < 6; i++) sched(mflo(5'd10), ex(1'b1, 2'b00, 2'b00, 1'b1));
    sched(mflo(5'd10), 6'b0);
    sched(nop(), 6'b0);
    for (int c = 0; prog_q.size() > 0; c++) begin
      apply(prog_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL md cycle %0d: got %b expected %b", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_reset();
    logic [5:0] e;
    drain();
    apply(md(1'b1));
    @(posedge clk); #1;
    apply(mflo(5'd10));
    repeat (3) @(posedge clk);
    exp_q.push_back(ex(1'b1, 2'b00, 2'b00, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL md_reset_busy: got %b expected %b", obs, e); end
    #1 reset = 1'b0;
    exp_q.push_back(6'b0);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL md_reset_abort: got %b expected %b", obs, e); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(mflo(5'd10));
    exp_q.push_back(6'b0);
    @(posedge clk); #1;
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin fails++; $display("FAIL md_reset_release: got %b expected %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_priority_zero();
    logic [5:0] e;
    drain();
    sched(alu(5'd4, 5'd0, 5'd0), 6'b0);
    sched(alu(5'd4, 5'd0, 5'd0), 6'b0);
    sched(alu(5'd11, 5'd4, 5'd0), 6'b0);
    sched(nop(), ex(1'b0, 2'b01, 2'b00, 1'b0));
    sched(alu(5'd0, 5'd0, 5'd0), 6'b0);
    sched(beq(5'd0, 5'd0), 6'b0);
    sched(nop(), 6'b0);
    for (int c = 0; prog_q.size() > 0; c++) begin
      apply(prog_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin fails++; $display("FAIL priority_zero cycle %0d: got %b expected %b", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    apply(nop());
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch_use();
    test_md();
    test_md_reset();
    test_priority_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/forward controller for the 5-stage pipeline.
- Keeps its own shadow pipeline of destination register and Tnew for the E, M and W stages, plus a busy counter for the multiply/divide unit.
- Compares each D-stage instruction's Tuse against in-flight Tnew and raises stall. While stalled, D holds and a bubble enters E.
- Drives the E-stage rs/rt forwarding select codes consumed by the E-stage operand muxes.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu enters E
DIV_CYCLES, 10, busy cycles after a div/divu enters E
REG_AW, 5, register index width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
d_rs  input  REG_AW  D-stage rs index
d_rt  input  REG_AW  D-stage rt index
d_rs_used  input  1  D instruction reads rs
d_rt_used  input  1  D instruction reads rt
d_tuse_rs  input  2  cycles until rs is needed (0 = needed in D, 1 = needed in E)
d_tuse_rt  input  2  same, for rt
d_dst  input  REG_AW  D-stage destination register; 0 = no write
d_tnew  input  2  cycles after E entry until the result can be forwarded (ALU = 1, load = 2, link = 0)
d_md_start  input  1  D instruction starts mult/div
d_md_div  input  1  qualifies d_md_start: 1 = div, 0 = mult
d_md_use  input  1  D instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo)
stall  output  1  freeze PC and the D register; insert a bubble into E
mfrse_c  output  2  E rs select: 00 = register file value, 01 = M-stage ALU result, 10 = W-stage write data
mfrte_c  output  2  E rt select, same encoding
md_busy  output  1  HI/LO unit busy

Behaviour:
- Reset (reset = 0, asynchronous):
  - All shadow fields cleared: E/M/W dst = 0, tnew = 0; E rs/rt = 0; E md_start = 0; md counter = 0.
  - Therefore stall = 0, mfrse_c = 00, mfrte_c = 00, md_busy = 0.
  - Reset asserted mid-stall or mid-divide aborts everything; the first cycle after release behaves as an empty pipe.
- Shadow pipeline, advancing every rising edge:
  - W takes M; tnew saturating-decrements (max(t-1, 0)).
  - M takes E; tnew saturating-decrements.
  - E takes D fields (rs, rt, dst, tnew, md_start) when stall = 0. When stall = 1, E takes a bubble: all fields 0.
- Stall logic (combinational from D inputs and shadow registers):
  - rs hazard: d_rs_used && d_rs != 0 && ((E.dst == d_rs && E.tnew > d_tuse_rs) || (M.dst == d_rs && M.tnew > d_tuse_rs)).
  - rt hazard: identical form.
  - md hazard: d_md_use && md_busy.
  - stall = rs hazard | rt hazard | md hazard.
  - W never causes a stall; the register file writes first-half / reads bypass.
- Forward selects (combinational from shadow registers only, so glitch-free relative to D inputs):
  - mfrse_c = 01 if E.rs != 0 && M.dst == E.rs && M.tnew == 0.
  - Otherwise 10 if E.rs != 0 && W.dst == E.rs && W.tnew == 0.
  - Otherwise 00.
  - mfrte_c follows the same rules using E.rt.
  - When M and W both match, M wins (newer value).
  - A matching dst with tnew != 0 never forwards; the stall logic guarantees this cannot reach E use.
- MD counter:
  - When E.md_start = 1 at an edge, the counter loads MULT_CYCLES or DIV_CYCLES per the registered div flag.
  - Otherwise it decrements while nonzero.
  - md_busy = E.md_start | (counter != 0). Busy therefore covers the cycle the start sits in E plus N further cycles.
  - A new md_start cannot enter E while busy, because d_md_use stalls it.
- Register $0: as dst it is never matched; as source it is never stalled or forwarded.

Test Plan:
- Reset then idle: hold reset = 0 for 3 cycles mid-traffic, release -> stall = 0, both selects = 00, md_busy = 0 on the first post-reset cycle.
- ALU→ALU: addu $1 (tnew 1), then addu using $1 with tuse 1 -> no stall; next cycle mfrse_c = 01. One instruction later with a gap -> mfrse_c = 10.
- Load-use: lw $2 (tnew 2), then addu rs = $2 with tuse 1 -> stall = 1 for exactly 1 cycle, E bubble inserted, then mfrse_c = 10 when addu reaches E.
- Branch-use: addu $3, then beq rs = $3 with tuse 0 -> stall for 1 cycle. lw $3 then beq -> stall for 2 cycles.
- MD: div, then mflo immediately -> md_busy high 11 cycles (E cycle + 10); mflo stalls until the cycle md_busy drops. Repeat with mult -> 6 cycles. Assert reset on cycle 4 of the div -> md_busy = 0 at once.
- Priority and $0: M and W both write $4, E reads $4 -> mfrse_c = 01. Instruction writing $0 followed by a reader of $0 -> no stall, select 00.
